// File: rtl/audio_mem_pkg.sv
// Shared definitions for the audio record/playback sequencer.
// Holds the sequencer state encoding, the memory command opcodes,
// the externally visible mode codes and a helper that maps a state
// onto its mode.
package audio_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REC_WAIT,
    REC_WDATA,
    REC_WCMD,
    PLAY_RCMD,
    PLAY_RWAIT,
    PLAY_HOLD,
    PLAY_DRAIN
  } state_e;

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_REC  = 2'b01;
  localparam logic [1:0] MODE_PLAY = 2'b10;

  // Every record state reports MODE_REC and every play state (including
  // the drain of an abandoned read) reports MODE_PLAY.
  function automatic logic [1:0] modeOf(input state_e s);
    case (s)
      IDLE:                          modeOf = MODE_IDLE;
      REC_WAIT, REC_WDATA, REC_WCMD: modeOf = MODE_REC;
      default:                       modeOf = MODE_PLAY;
    endcase
  endfunction

endpackage

// File: rtl/audio_ptr_ctr.sv
// Word pointer used by the sequencer for both the record (write) and
// playback (read) positions.
// Ports:
//   clk_i    system clock
//   reset_i  synchronous active-high reset, pointer returns to 0
//   clr_i    synchronous clear to 0 (wins over increment)
//   inc_i    advance the pointer by one word
//   limit_i  value the pointer is compared against
//   ptr_o    current word pointer
//   hit_o    high while ptr_o equals limit_i
module audio_ptr_ctr
  import audio_mem_pkg::*;
#(
  parameter int ADDR_W = 30
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              clr_i,
  input  logic              inc_i,
  input  logic [ADDR_W-1:0] limit_i,
  output logic [ADDR_W-1:0] ptr_o,
  output logic              hit_o
);

  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;
  assign hit_o = (ptr_q == limit_i);

endmodule

// File: rtl/audio_mem_sequencer.sv
// Sequences audio record/playback traffic between the codec sample
// streams and the DDR memory-controller user port. Recording writes
// ADC samples to consecutive RAM words; playback reads them back one
// word ahead of the DAC and hands each over on dac_req_i.
// Optional feature macro: LOOP_PLAY_EN - when defined, playback wraps
// to word 0 at the end of the recording and repeats until stopped.
// Ports:
//   clk_i, reset_i                    clock, synchronous active-high reset
//   rec_start_i, play_start_i, stop_i control pulses
//   mode_o                            00 idle, 01 record, 10 play
//   rec_len_o                         words recorded so far
//   overrun_o, underrun_o             sticky dropped-sample / starved-DAC flags
//   adc_valid_i, adc_data_i           incoming ADC samples
//   dac_req_i, dac_data_o             DAC sample handshake
//   mem_*                             memory-controller user port
module audio_mem_sequencer
  import audio_mem_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 30,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                MAX_WORDS = 1048576
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              rec_start_i,
  input  logic              play_start_i,
  input  logic              stop_i,
  output logic [1:0]        mode_o,
  output logic [ADDR_W-1:0] rec_len_o,
  output logic              overrun_o,
  output logic              underrun_o,
  input  logic              adc_valid_i,
  input  logic [DATA_W-1:0] adc_data_i,
  input  logic              dac_req_i,
  output logic [DATA_W-1:0] dac_data_o,
  input  logic              mem_calib_done_i,
  output logic              mem_cmd_en_o,
  output logic [2:0]        mem_cmd_instr_o,
  output logic [ADDR_W-1:0] mem_cmd_addr_o,
  input  logic              mem_cmd_full_i,
  output logic              mem_wr_en_o,
  output logic [DATA_W-1:0] mem_wr_data_o,
  input  logic              mem_wr_full_i,
  output logic              mem_rd_en_o,
  input  logic [DATA_W-1:0] mem_rd_data_i,
  input  logic              mem_rd_empty_i
);

`ifdef LOOP_PLAY_EN
  localparam logic LOOP_EN = 1'b1;
`else
  localparam logic LOOP_EN = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MAX_WORDS - 1);

  state_e            state_q;
  logic [DATA_W-1:0] holdData_q;
  logic [DATA_W-1:0] nextBuf_q;
  logic [DATA_W-1:0] dacData_q;
  logic [ADDR_W-1:0] recLen_q;
  logic              overrun_q;
  logic              underrun_q;
  logic              stopPend_q;

  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic              wptrLast;
  logic              rptrEnd;

  logic recAccept, playAccept;
  logic wrFire, wrCmdFire, rdCmdFire, rdTake, drainPop, holdTake, rptrClr;

  // A start is only honoured once memory is calibrated and no stop is
  // present; record wins over play, and play needs something recorded.
  // A stop seen in PLAY_RCMD suppresses the read command so nothing is
  // left outstanding, and a stop seen in PLAY_RWAIT defers the pop to
  // PLAY_DRAIN so the read FIFO stays aligned.
  always_comb begin
    recAccept  = (state_q == IDLE) && mem_calib_done_i && !stop_i && rec_start_i;
    playAccept = (state_q == IDLE) && mem_calib_done_i && !stop_i && !rec_start_i
                 && play_start_i && (recLen_q != '0);
    wrFire     = (state_q == REC_WDATA) && !mem_wr_full_i;
    wrCmdFire  = (state_q == REC_WCMD) && !mem_cmd_full_i;
    rdCmdFire  = (state_q == PLAY_RCMD) && !stop_i && !mem_cmd_full_i;
    rdTake     = (state_q == PLAY_RWAIT) && !stop_i && !mem_rd_empty_i;
    drainPop   = (state_q == PLAY_DRAIN) && !mem_rd_empty_i;
    holdTake   = (state_q == PLAY_HOLD) && !stop_i && dac_req_i;
    rptrClr    = playAccept || (LOOP_EN && holdTake && rptrEnd);
  end

  audio_ptr_ctr #(.ADDR_W(ADDR_W)) u_wptr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr_i   (recAccept),
    .inc_i   (wrCmdFire),
    .limit_i (LAST_WORD),
    .ptr_o   (wptr),
    .hit_o   (wptrLast)
  );

  // The read pointer advances when a word is popped, so it already
  // points past the held word; equality with rec_len marks end of data.
  audio_ptr_ctr #(.ADDR_W(ADDR_W)) u_rptr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr_i   (rptrClr),
    .inc_i   (rdTake),
    .limit_i (recLen_q),
    .ptr_o   (rptr),
    .hit_o   (rptrEnd)
  );

  // Main sequencer. Stops arriving while a record word is in flight are
  // remembered so the word still reaches memory before returning idle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      holdData_q <= '0;
      nextBuf_q  <= '0;
      dacData_q  <= '0;
      recLen_q   <= '0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
      stopPend_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (recAccept) begin
            state_q    <= REC_WAIT;
            recLen_q   <= '0;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
            stopPend_q <= 1'b0;
          end else if (playAccept) begin
            state_q    <= PLAY_RCMD;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
          end
        end
        REC_WAIT: begin
          if (stop_i) begin
            state_q <= IDLE;
          end else if (adc_valid_i) begin
            holdData_q <= adc_data_i;
            state_q    <= REC_WDATA;
          end
        end
        REC_WDATA: begin
          if (stop_i) stopPend_q <= 1'b1;
          if (adc_valid_i) overrun_q <= 1'b1;
          if (wrFire) state_q <= REC_WCMD;
        end
        REC_WCMD: begin
          if (adc_valid_i) overrun_q <= 1'b1;
          if (wrCmdFire) begin
            recLen_q <= wptr + ADDR_W'(1);
            if (wptrLast || stopPend_q || stop_i) begin
              state_q    <= IDLE;
              stopPend_q <= 1'b0;
            end else begin
              state_q <= REC_WAIT;
            end
          end else if (stop_i) begin
            stopPend_q <= 1'b1;
          end
        end
        PLAY_RCMD: begin
          if (dac_req_i) underrun_q <= 1'b1;
          if (stop_i) begin
            state_q <= IDLE;
          end else if (rdCmdFire) begin
            state_q <= PLAY_RWAIT;
          end
        end
        PLAY_RWAIT: begin
          if (dac_req_i) underrun_q <= 1'b1;
          if (stop_i) begin
            state_q <= PLAY_DRAIN;
          end else if (rdTake) begin
            nextBuf_q <= mem_rd_data_i;
            state_q   <= PLAY_HOLD;
          end
        end
        PLAY_HOLD: begin
          if (stop_i) begin
            state_q <= IDLE;
          end else if (holdTake) begin
            dacData_q <= nextBuf_q;
            if (rptrEnd && !LOOP_EN) begin
              state_q <= IDLE;
            end else begin
              state_q <= PLAY_RCMD;
            end
          end
        end
        PLAY_DRAIN: begin
          if (dac_req_i) underrun_q <= 1'b1;
          if (drainPop) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Memory strobes are decoded from the current state so a word reaches
  // the FIFO one cycle after its sample and the command one cycle later.
  always_comb begin
    mem_cmd_en_o    = wrCmdFire || rdCmdFire;
    mem_cmd_instr_o = rdCmdFire ? CMD_RD : CMD_WR;
    mem_cmd_addr_o  = '0;
    if (wrCmdFire) begin
      mem_cmd_addr_o = BASE_ADDR + (wptr << 2);
    end else if (rdCmdFire) begin
      mem_cmd_addr_o = BASE_ADDR + (rptr << 2);
    end
  end

  assign mem_wr_en_o   = wrFire;
  assign mem_wr_data_o = holdData_q;
  assign mem_rd_en_o   = rdTake || drainPop;

  assign mode_o     = modeOf(state_q);
  assign rec_len_o  = recLen_q;
  assign overrun_o  = overrun_q;
  assign underrun_o = underrun_q;
  assign dac_data_o = dacData_q;

endmodule

// File: tb/tb_audio_mem_sequencer.sv
// Directed bench for audio_mem_sequencer with a small memory model.
// Expected write commands, read addresses and DAC samples are queued
// when stimulus is driven and checked as the design produces them.
module tb_audio_mem_sequencer;

  localparam logic [4:0] S_REC  = 5'b10000;
  localparam logic [4:0] S_PLAY = 5'b01000;
  localparam logic [4:0] S_STOP = 5'b00100;
  localparam logic [4:0] S_ADC  = 5'b00010;
  localparam logic [4:0] S_DAC  = 5'b00001;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        recStart = 1'b0, playStart = 1'b0, stop = 1'b0;
  logic [1:0]  mode;
  logic [29:0] recLen;
  logic        overrun, underrun;
  logic        adcValid = 1'b0;
  logic [31:0] adcData = '0;
  logic        dacReq = 1'b0;
  logic [31:0] dacData;
  logic        calib = 1'b0;
  logic        memCmdEn;
  logic [2:0]  memCmdInstr;
  logic [29:0] memCmdAddr;
  logic        memCmdFull = 1'b0;
  logic        memWrEn;
  logic [31:0] memWrData;
  logic        memWrFull = 1'b0;
  logic        memRdEn;
  logic [31:0] memRdData;
  logic        memRdEmpty;
  logic        forceEmpty = 1'b0;

  int numChecks = 0;
  int numFails = 0;
  int extraEvents = 0;
  int rdPops = 0;
  int wrCmdCount = 0;
  int rdCount = 0;
  int snap;
  logic [31:0] rdHead = '0;

  logic [63:0] expWr[$];
  logic [29:0] expRd[$];
  logic [31:0] expDac[$];
  logic [31:0] wdQ[$];
  logic [31:0] rdQ[$];
  logic [31:0] memArr [0:15];

  logic        sReset = 1'b1, sCmdEn = 1'b0, sWrEn = 1'b0, sRdEn = 1'b0;
  logic [2:0]  sInstr = '0;
  logic [29:0] sAddr = '0;
  logic [31:0] sWrData = '0;
  logic [31:0] wd, prevDac = '0;
  logic [63:0] e64;
  logic [31:0] e32;
  logic [29:0] e30;

  always #5 clk = ~clk;

  assign memRdEmpty = forceEmpty || (rdCount == 0);
  assign memRdData  = rdHead;

  audio_mem_sequencer #(
    .DATA_W(32), .ADDR_W(30), .BASE_ADDR(30'd0), .MAX_WORDS(8)
  ) dut (
    .clk_i(clk), .reset_i(reset),
    .rec_start_i(recStart), .play_start_i(playStart), .stop_i(stop),
    .mode_o(mode), .rec_len_o(recLen), .overrun_o(overrun), .underrun_o(underrun),
    .adc_valid_i(adcValid), .adc_data_i(adcData),
    .dac_req_i(dacReq), .dac_data_o(dacData),
    .mem_calib_done_i(calib),
    .mem_cmd_en_o(memCmdEn), .mem_cmd_instr_o(memCmdInstr), .mem_cmd_addr_o(memCmdAddr),
    .mem_cmd_full_i(memCmdFull),
    .mem_wr_en_o(memWrEn), .mem_wr_data_o(memWrData), .mem_wr_full_i(memWrFull),
    .mem_rd_en_o(memRdEn), .mem_rd_data_i(memRdData), .mem_rd_empty_i(memRdEmpty)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    numChecks++;
    assert (observed === expected) else begin
      numFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Holds the selected strobes for exactly one rising edge.
  task automatic applyStimulus(input logic [4:0] strobes, input logic [31:0] data);
    {recStart, playStart, stop, adcValid, dacReq} = strobes;
    adcData = data;
    tick(1);
    {recStart, playStart, stop, adcValid, dacReq} = '0;
  endtask

  // Strobes are sampled mid-cycle; they take effect on the next rising edge.
  always @(negedge clk) begin
    sReset  = reset;
    sCmdEn  = memCmdEn;
    sInstr  = memCmdInstr;
    sAddr   = memCmdAddr;
    sWrEn   = memWrEn;
    sWrData = memWrData;
    sRdEn   = memRdEn;
  end

  // Memory model and scoreboard, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (sReset) begin
      wdQ.delete();
      rdQ.delete();
    end else begin
      if (sWrEn) wdQ.push_back(sWrData);
      if (sCmdEn && sInstr == 3'b000) begin
        wrCmdCount++;
        wd = 'x;
        if (wdQ.size() > 0) wd = wdQ.pop_front();
        memArr[sAddr[5:2]] = wd;
        if (expWr.size() > 0) begin
          e64 = expWr.pop_front();
          checkOutput("wr_cmd", {2'b00, sAddr, wd}, e64);
        end else begin
          extraEvents++;
        end
      end else if (sCmdEn && sInstr == 3'b001) begin
        rdQ.push_back(memArr[sAddr[5:2]]);
        if (expRd.size() > 0) begin
          e30 = expRd.pop_front();
          checkOutput("rd_addr", {34'd0, sAddr}, {34'd0, e30});
        end else begin
          extraEvents++;
        end
      end else if (sCmdEn) begin
        extraEvents++;
      end
      if (sRdEn) begin
        rdPops++;
        if (rdQ.size() > 0) void'(rdQ.pop_front());
        else extraEvents++;
      end
      if (dacData !== prevDac) begin
        if (expDac.size() > 0) begin
          e32 = expDac.pop_front();
          checkOutput("dac_data", {32'd0, dacData}, {32'd0, e32});
        end else begin
          extraEvents++;
        end
        prevDac = dacData;
      end
    end
    rdCount = rdQ.size();
    rdHead = '0;
    if (rdQ.size() > 0) rdHead = rdQ[0];
  end

  initial begin
    tick(3);
    reset = 1'b0;
    tick(1);
    checkOutput("reset_mode", {62'd0, mode}, 64'd0);
    checkOutput("reset_rec_len", {34'd0, recLen}, 64'd0);
    checkOutput("reset_overrun", {63'd0, overrun}, 64'd0);
    checkOutput("reset_underrun", {63'd0, underrun}, 64'd0);
    checkOutput("reset_dac", {32'd0, dacData}, 64'd0);
    checkOutput("reset_strobes", {61'd0, memCmdEn, memWrEn, memRdEn}, 64'd0);

    // Starts before calibration, play with nothing recorded, stop priority.
    applyStimulus(S_REC, '0);
    checkOutput("no_calib_mode", {62'd0, mode}, 64'd0);
    calib = 1'b1;
    applyStimulus(S_PLAY, '0);
    checkOutput("play_empty_mode", {62'd0, mode}, 64'd0);
    applyStimulus(S_REC | S_STOP, '0);
    checkOutput("stop_prio_mode", {62'd0, mode}, 64'd0);

    // Test 1: three samples then stop.
    $display("[TB] record three samples");
    applyStimulus(S_REC, '0);
    checkOutput("t1_mode_rec", {62'd0, mode}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      e64 = {2'b00, 30'(i * 4), 32'(32'hA1 + i)};
      expWr.push_back(e64);
      applyStimulus(S_ADC, 32'(32'hA1 + i));
      if (i == 0) begin
        checkOutput("t1_lat_wr_en", {62'd0, memWrEn, memCmdEn}, 64'd2);
        tick(1);
        checkOutput("t1_lat_cmd_en", {62'd0, memWrEn, memCmdEn}, 64'd1);
        tick(8);
      end else begin
        tick(9);
      end
    end
    applyStimulus(S_STOP, '0);
    tick(1);
    checkOutput("t1_mode_idle", {62'd0, mode}, 64'd0);
    checkOutput("t1_rec_len", {34'd0, recLen}, 64'd3);
    checkOutput("t1_wr_pending", 64'(expWr.size()), 64'd0);

    // Test 2: play the three samples back.
    $display("[TB] play three samples");
    expRd.push_back(30'd0);
    expRd.push_back(30'd4);
    expRd.push_back(30'd8);
    applyStimulus(S_PLAY, '0);
    tick(5);
    checkOutput("t2_mode_play", {62'd0, mode}, 64'd2);
    for (int i = 0; i < 3; i++) begin
      expDac.push_back(32'(32'hA1 + i));
      applyStimulus(S_DAC, '0);
      if (i < 2) tick(9);
    end
`ifdef LOOP_PLAY_EN
    expRd.push_back(30'd0);
    tick(4);
    applyStimulus(S_STOP, '0);
`endif
    tick(2);
    checkOutput("t2_mode_idle", {62'd0, mode}, 64'd0);
    checkOutput("t2_underrun", {63'd0, underrun}, 64'd0);
    checkOutput("t2_dac_pending", 64'(expDac.size()), 64'd0);
    checkOutput("t2_rd_pending", 64'(expRd.size()), 64'd0);
    checkOutput("t2_dac_last", {32'd0, dacData}, 64'hA3);

    // Test 3: write FIFO full while a second sample arrives.
    $display("[TB] write backpressure");
    applyStimulus(S_REC, '0);
    checkOutput("t3_rec_len_clr", {34'd0, recLen}, 64'd0);
    memWrFull = 1'b1;
    expWr.push_back({2'b00, 30'd0, 32'hB1});
    applyStimulus(S_ADC, 32'hB1);
    tick(3);
    applyStimulus(S_ADC, 32'hB2);
    tick(1);
    checkOutput("t3_overrun", {63'd0, overrun}, 64'd1);
    checkOutput("t3_wr_blocked", {63'd0, memWrEn}, 64'd0);
    tick(14);
    memWrFull = 1'b0;
    tick(4);
    checkOutput("t3_wr_pending", 64'(expWr.size()), 64'd0);
    checkOutput("t3_rec_len", {34'd0, recLen}, 64'd1);
    checkOutput("t3_mode_rec", {62'd0, mode}, 64'd1);
    expWr.push_back({2'b00, 30'd4, 32'hB3});
    applyStimulus(S_ADC, 32'hB3);
    tick(4);
    checkOutput("t3_resume_len", {34'd0, recLen}, 64'd2);
    applyStimulus(S_STOP, '0);
    checkOutput("t3_overrun_sticky", {63'd0, overrun}, 64'd1);

    // Test 4: record up to the word limit without a stop.
    $display("[TB] record to limit");
    applyStimulus(S_REC, '0);
    checkOutput("t4_overrun_clr", {63'd0, overrun}, 64'd0);
    for (int i = 0; i < 8; i++) begin
      expWr.push_back({2'b00, 30'(i * 4), 32'(32'hC0 + i)});
      applyStimulus(S_ADC, 32'(32'hC0 + i));
      tick(4);
    end
    checkOutput("t4_mode_idle", {62'd0, mode}, 64'd0);
    checkOutput("t4_rec_len", {34'd0, recLen}, 64'd8);
    checkOutput("t4_wr_pending", 64'(expWr.size()), 64'd0);
    snap = wrCmdCount;
    applyStimulus(S_ADC, 32'hDEAD);
    tick(5);
    checkOutput("t4_no_cmd", 64'(wrCmdCount), 64'(snap));
    checkOutput("t4_no_overrun", {63'd0, overrun}, 64'd0);

    // Test 5: stop while waiting on an empty read FIFO.
    $display("[TB] stop during read wait");
    snap = rdPops;
    expRd.push_back(30'd0);
    forceEmpty = 1'b1;
    applyStimulus(S_PLAY, '0);
    tick(1);
    applyStimulus(S_DAC, '0);
    checkOutput("t5_underrun", {63'd0, underrun}, 64'd1);
    applyStimulus(S_STOP, '0);
    checkOutput("t5_mode_drain", {62'd0, mode}, 64'd2);
    checkOutput("t5_no_pop_yet", {63'd0, memRdEn}, 64'd0);
    tick(2);
    forceEmpty = 1'b0;
    tick(3);
    checkOutput("t5_pops", 64'(rdPops - snap), 64'd1);
    checkOutput("t5_dac_held", {32'd0, dacData}, 64'hA3);
    checkOutput("t5_mode_idle", {62'd0, mode}, 64'd0);
    checkOutput("t5_fifo_aligned", 64'(rdCount), 64'd0);
    checkOutput("t5_rd_pending", 64'(expRd.size()), 64'd0);

    // Test 6: two-word recording played to the end (or looped).
    $display("[TB] two-word playback");
    applyStimulus(S_REC, '0);
    expWr.push_back({2'b00, 30'd0, 32'hA1});
    applyStimulus(S_ADC, 32'hA1);
    tick(4);
    expWr.push_back({2'b00, 30'd4, 32'hA2});
    applyStimulus(S_ADC, 32'hA2);
    tick(4);
    applyStimulus(S_STOP, '0);
    checkOutput("t6_rec_len", {34'd0, recLen}, 64'd2);
    expRd.push_back(30'd0);
    expRd.push_back(30'd4);
`ifdef LOOP_PLAY_EN
    expRd.push_back(30'd0);
    expRd.push_back(30'd4);
    expRd.push_back(30'd0);
    for (int i = 0; i < 4; i++) begin
`else
    for (int i = 0; i < 2; i++) begin
`endif
      if (i == 0) begin
        applyStimulus(S_PLAY, '0);
        tick(5);
      end
      expDac.push_back((i % 2 == 0) ? 32'hA1 : 32'hA2);
      applyStimulus(S_DAC, '0);
      tick(9);
    end
`ifdef LOOP_PLAY_EN
    checkOutput("t6_loop_mode", {62'd0, mode}, 64'd2);
    applyStimulus(S_STOP, '0);
    tick(2);
`endif
    checkOutput("t6_mode_idle", {62'd0, mode}, 64'd0);
    checkOutput("t6_dac_last", {32'd0, dacData}, 64'hA2);
    checkOutput("t6_dac_pending", 64'(expDac.size()), 64'd0);
    checkOutput("t6_rd_pending", 64'(expRd.size()), 64'd0);
    checkOutput("unexpected_events", 64'(extraEvents), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
